div_sched: RTL and testbench

DIV_SCHED -- requirements
Module: div_sched

---
 rtl/div_sched.sv | 164 ++++++++++++++++
 tb/tb_div_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
// div_sched: round-robin scheduler that shares one multi-cycle divider
// among NREQ requesters. One operation is in flight at a time:
//   IDLE  -> grant a requester, latch its operands
//   ISSUE -> one-cycle div_start with the latched operands
//   WAIT  -> hold the command until div_done, capture the results
//   RESP  -> present the results to the owner until it consumes them
//
// Optional feature (define to enable):
//   DIV_SCHED_ZERO_BYPASS_EN - a granted request whose divider is zero
//   skips the divider and answers directly with quotient all-ones and
//   remainder equal to the dividend.
module div_sched #(
  parameter int width = 6,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_sign,
  input  logic [NREQ*width-1:0]   req_dividend,
  input  logic [NREQ*width-1:0]   req_divider,
  output logic [NREQ-1:0]         req_ack,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [width-1:0]        rsp_quotient,
  output logic [width-1:0]        rsp_remainder,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic                    div_start,
  output logic                    div_sign,
  output logic [width-1:0]        div_dividend,
  output logic [width-1:0]        div_divider,
  input  logic                    div_done,
  input  logic [width-1:0]        div_quotient,
  input  logic [width-1:0]        div_remainder
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      own_idx;
  logic               op_sign;
  logic [width-1:0]   op_dividend, op_divider;
  logic [width-1:0]   res_q, res_r;

  logic               gnt_found, gnt_go, zero_byp;
  logic [PW-1:0]      gnt_idx, rr_nxt;
  logic               gnt_sign;
  logic [width-1:0]   gnt_dividend, gnt_divider;

  // Cyclic index helper: (base + off) mod NREQ, with off < NREQ.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return PW'(sum);
  endfunction

  // Find the first pending requester at or after rr_ptr (cyclic search).
  // NOTE: every variable written in a combinational block gets a default
  // first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    // Walk from the farthest slot back to rr_ptr so the nearest hit wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_add(rr_ptr, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_add(rr_ptr, k);
      end
    end
  end

  assign gnt_sign     = req_sign[gnt_idx];
  assign gnt_dividend = req_dividend[gnt_idx*width +: width];
  assign gnt_divider  = req_divider[gnt_idx*width +: width];
  assign rr_nxt       = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);

  // A grant only happens in IDLE and never while reset is applied.
  assign gnt_go = (state == IDLE) && gnt_found && rst_n;

`ifdef DIV_SCHED_ZERO_BYPASS_EN
  assign zero_byp = gnt_go && (gnt_divider == '0);
`else
  assign zero_byp = 1'b0;
`endif

  // Next-state and output decode; every output is zero unless its state drives it.
  always_comb begin
    state_nxt     = state;
    req_ack       = '0;
    rsp_valid     = '0;
    rsp_quotient  = '0;
    rsp_remainder = '0;
    div_start     = 1'b0;
    div_sign      = 1'b0;
    div_dividend  = '0;
    div_divider   = '0;
    case (state)
      IDLE: begin
        if (gnt_go) begin
          req_ack[gnt_idx] = 1'b1;
          state_nxt        = zero_byp ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        div_start    = 1'b1;
        div_sign     = op_sign;
        div_dividend = op_dividend;
        div_divider  = op_divider;
        state_nxt    = WAIT;
      end
      WAIT: begin
        div_sign     = op_sign;
        div_dividend = op_dividend;
        div_divider  = op_divider;
        if (div_done) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[own_idx] = 1'b1;
        rsp_quotient       = res_q;
        rsp_remainder      = res_r;
        // Only the owner's ready bit completes the handshake.
        if (rsp_ready[own_idx]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus operand/result capture, synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      own_idx     <= '0;
      op_sign     <= 1'b0;
      op_dividend <= '0;
      op_divider  <= '0;
      res_q       <= '0;
      res_r       <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_go) begin
        own_idx     <= gnt_idx;
        rr_ptr      <= rr_nxt;
        op_sign     <= gnt_sign;
        op_dividend <= gnt_dividend;
        op_divider  <= gnt_divider;
        if (zero_byp) begin
          res_q <= '1;
          res_r <= gnt_dividend;
        end
      end
      if (state == WAIT && div_done) begin
        res_q <= div_quotient;
        res_r <= div_remainder;
      end
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Directed self-checking bench for div_sched (width=6, NREQ=4).
// The divider is played by the bench: it raises div_done with
// hand-chosen results while the scheduler is waiting.
module tb_div_sched;

  localparam int W = 6;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_sign, req_ack;
  logic [N*W-1:0] req_dividend, req_divider;
  logic [N-1:0]   rsp_valid, rsp_ready;
  logic [W-1:0]   rsp_quotient, rsp_remainder;
  logic           div_start, div_sign, div_done;
  logic [W-1:0]   div_dividend, div_divider, div_quotient, div_remainder;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  div_sched #(.width(W), .NREQ(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_sign     (req_sign),
    .req_dividend (req_dividend),
    .req_divider  (req_divider),
    .req_ack      (req_ack),
    .rsp_valid    (rsp_valid),
    .rsp_quotient (rsp_quotient),
    .rsp_remainder(rsp_remainder),
    .rsp_ready    (rsp_ready),
    .div_start    (div_start),
    .div_sign     (div_sign),
    .div_dividend (div_dividend),
    .div_divider  (div_divider),
    .div_done     (div_done),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    req_dividend[i*W +: W] = a;
    req_divider[i*W +: W]  = b;
    req_sign[i]            = s;
  endtask

  // Called while the scheduler is in WAIT; returns in RESP.
  task automatic finish_div(input logic [W-1:0] q, input logic [W-1:0] r);
    div_done      = 1'b1;
    div_quotient  = q;
    div_remainder = r;
    tick();
    div_done      = 1'b0;
    div_quotient  = '0;
    div_remainder = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_g [5];
    int acks;
    int starts;
    exp_g = '{0, 1, 2, 3, 0};

    // Reset with a request already pending: nothing may leak out.
    rst_n = 1'b0; req_valid = 4'b0010; req_sign = '0;
    req_dividend = '0; req_divider = '0; rsp_ready = '0;
    div_done = 1'b0; div_quotient = '0; div_remainder = '0;
    tick(); tick();
    check("rst ack",       req_ack,      0);
    check("rst rsp_valid", rsp_valid,    0);
    check("rst div_start", div_start,    0);
    check("rst dividend",  div_dividend, 0);
    check("rst quotient",  rsp_quotient, 0);

    // Single request: 45/7 from requester 1, divider done 6 cycles after start.
    set_op(1, 6'd45, 6'd7, 1'b0);
    rst_n = 1'b1;
    #1;
    check("t1 ack", req_ack, 4'b0010);
    tick();                                   // ISSUE
    req_valid = '0;
    set_op(1, 6'd0, 6'd0, 1'b0);              // operands already latched
    #1;
    check("t1 start",    div_start,    1);
    check("t1 dividend", div_dividend, 45);
    check("t1 divider",  div_divider,  7);
    check("t1 sign",     div_sign,     0);
    starts = 0;
    for (int k = 0; k < 5; k++) begin
      tick();                                 // WAIT
      starts += int'(div_start);
      check("t1 hold dividend", div_dividend, 45);
    end
    check("t1 single start", starts, 0);
    tick();                                   // sixth cycle after start
    finish_div(6'd6, 6'd3);                   // RESP
    check("t1 rsp_valid", rsp_valid,     4'b0010);
    check("t1 quotient",  rsp_quotient,  6);
    check("t1 remainder", rsp_remainder, 3);
    rsp_ready = 4'b0010;
    tick();                                   // IDLE
    rsp_ready = '0;
    #1;
    check("t1 idle rsp_valid", rsp_valid,    0);
    check("t1 idle quotient",  rsp_quotient, 0);

    // Round robin: all requesting, results consumed immediately.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, 6'((i + 1) * 10), 6'(i + 1), 1'b0);
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      #1;
      acks = $countones(req_ack);
      check("rr ack", req_ack, 1 << exp_g[t]);
      tick();                                 // ISSUE
      acks += $countones(req_ack);
      check("rr start",    div_start,    1);
      check("rr dividend", div_dividend, (exp_g[t] + 1) * 10);
      tick();                                 // WAIT
      acks += $countones(req_ack);
      finish_div(6'(t + 1), 6'd0);            // RESP
      acks += $countones(req_ack);
      check("rr rsp_valid", rsp_valid,    1 << exp_g[t]);
      check("rr quotient",  rsp_quotient, t + 1);
      tick();                                 // IDLE
      check("rr one ack", acks, 1);
    end

    // Backpressure on requester 2 while others request and assert ready.
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    tick();
    rst_n = 1'b1;
    set_op(2, 6'd11, 6'd2, 1'b0);
    req_valid = 4'b0100;
    #1;
    check("bp ack", req_ack, 4'b0100);
    tick();                                   // ISSUE
    req_valid = 4'b1011;
    tick();                                   // WAIT
    finish_div(6'd5, 6'd1);                   // RESP
    rsp_ready = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp rsp_valid", rsp_valid,     4'b0100);
      check("bp quotient",  rsp_quotient,  5);
      check("bp remainder", rsp_remainder, 1);
      check("bp no ack",    req_ack,       0);
      tick();
    end
    rsp_ready = 4'b0100;
    #1;
    check("bp last rsp_valid", rsp_valid, 4'b0100);
    tick();                                   // IDLE
    rsp_ready = '0;
    set_op(3, 6'd20, 6'd4, 1'b0);
    #1;
    check("bp next ack", req_ack,   4'b1000);
    check("bp idle rsp", rsp_valid, 0);

    // Stray signals: non-owner ready while owner is 3, div_done in IDLE.
    tick();                                   // ISSUE (owner 3)
    req_valid = '0;
    check("st start",    div_start,    1);
    check("st dividend", div_dividend, 20);
    tick();                                   // WAIT
    finish_div(6'd5, 6'd0);                   // RESP
    rsp_ready = 4'b0001;
    #1;
    check("st rsp_valid", rsp_valid, 4'b1000);
    tick();
    check("st still rsp", rsp_valid, 4'b1000);
    rsp_ready = 4'b1000;
    tick();                                   // IDLE
    rsp_ready = '0;
    div_done = 1'b1;
    div_quotient = 6'd7;
    tick();
    div_done = 1'b0;
    div_quotient = '0;
    check("st done rsp",   rsp_valid,    0);
    check("st done quot",  rsp_quotient, 0);
    check("st done start", div_start,    0);
    tick();
    check("st idle rsp", rsp_valid, 0);
    set_op(0, 6'd9, 6'd2, 1'b0);
    req_valid = 4'b0001;
    #1;
    check("st idle ack", req_ack, 4'b0001);

    // Reset while waiting on the divider, then a late div_done.
    tick();                                   // ISSUE
    req_valid = '0;
    check("rw start",    div_start,    1);
    check("rw dividend", div_dividend, 9);
    tick();                                   // WAIT
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rw dividend 0", div_dividend, 0);
    check("rw rsp_valid",  rsp_valid,    0);
    div_done = 1'b1;
    div_quotient = 6'd4;
    div_remainder = 6'd1;
    tick();
    div_done = 1'b0;
    div_quotient = '0;
    div_remainder = '0;
    check("rw late rsp",   rsp_valid,    0);
    check("rw late quot",  rsp_quotient, 0);
    check("rw late start", div_start,    0);
    tick();
    check("rw idle rsp", rsp_valid, 0);

    // Zero divider: 13/0 from requester 1.
    set_op(1, 6'd13, 6'd0, 1'b0);
    req_valid = 4'b0010;
    #1;
    check("z ack", req_ack, 4'b0010);
    tick();
    req_valid = '0;
`ifdef DIV_SCHED_ZERO_BYPASS_EN
    check("z no start",  div_start,     0);
    check("z rsp_valid", rsp_valid,     4'b0010);
    check("z quotient",  rsp_quotient,  6'h3F);
    check("z remainder", rsp_remainder, 13);
`else
    check("z start",     div_start,    1);
    check("z divider",   div_divider,  0);
    check("z dividend",  div_dividend, 13);
    tick();                                   // WAIT
    finish_div(6'h3F, 6'd13);                 // RESP
    check("z rsp_valid", rsp_valid,     4'b0010);
    check("z remainder", rsp_remainder, 13);
`endif
    rsp_ready = 4'b0010;
    tick();
    rsp_ready = '0;
    check("z idle rsp", rsp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
